// File: rtl/z80_block_compare_engine.sv
// Z80 block-compare engine (CPI/CPD/CPIR/CPDR): one (HL) read per iteration over req/ack, flags from A-(HL).
// Define Z80_UNDOC_FLAGS_EN to drive F5/F3 with the undocumented Z80 behaviour instead of preserving them.
module z80_block_compare_engine #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode_dec,
    input  logic              mode_rep,
    input  logic              abort,
    input  logic [DATA_W-1:0] a_in,
    input  logic [ADDR_W-1:0] hl_in,
    input  logic [CNT_W-1:0]  bc_in,
    input  logic [DATA_W-1:0] f_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] hl_out,
    output logic [CNT_W-1:0]  bc_out,
    output logic [DATA_W-1:0] f_out,
    output logic [CNT_W-1:0]  iter_cnt
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | mem_req held on (HL) until mem_ack, or abort without ack
    // EXEC  | one cycle: flags from A-m, step HL, decrement BC
    // DONE  | one-cycle done pulse, back to IDLE
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] a_q, m_q;
    logic              dec_q, rep_q;

    logic [DATA_W-1:0] sub;
    logic [CNT_W-1:0]  bc_dec;
    logic [ADDR_W-1:0] hl_step;
    logic              z_new, h_new, v_new;
    logic [DATA_W-1:0] f_new;

    assign mem_addr = hl_out;

    always_comb begin
        sub     = a_q - m_q;
        bc_dec  = bc_out - CNT_W'(1);
        hl_step = dec_q ? (hl_out - ADDR_W'(1)) : (hl_out + ADDR_W'(1));
        z_new   = (sub == '0);
        h_new   = (a_q[3:0] < m_q[3:0]);
        v_new   = (bc_dec != '0);
        f_new    = f_out;
        f_new[7] = sub[7];
        f_new[6] = z_new;
        f_new[4] = h_new;
        f_new[2] = v_new;
        f_new[1] = 1'b1;
`ifdef Z80_UNDOC_FLAGS_EN
        begin
            logic [DATA_W-1:0] n_val;
            n_val    = sub - DATA_W'(h_new);
            f_new[5] = n_val[1];
            f_new[3] = n_val[3];
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_READ;
            end
            S_READ: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                // ack wins over a simultaneous abort
                if (mem_ack)    state_nxt = S_EXEC;
                else if (abort) state_nxt = S_DONE;
            end
            S_EXEC: begin
                busy = 1'b1;
                if (rep_q && v_new && !z_new && !abort) state_nxt = S_READ;
                else                                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            a_q      <= '0;
            m_q      <= '0;
            dec_q    <= 1'b0;
            rep_q    <= 1'b0;
            hl_out   <= '0;
            bc_out   <= '0;
            f_out    <= '0;
            iter_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= a_in;
                        dec_q    <= mode_dec;
                        rep_q    <= mode_rep;
                        hl_out   <= hl_in;
                        bc_out   <= bc_in;
                        f_out    <= f_in;
                        iter_cnt <= '0;
                    end
                end
                S_READ: begin
                    if (mem_ack) m_q <= mem_rdata;
                end
                S_EXEC: begin
                    hl_out   <= hl_step;
                    bc_out   <= bc_dec;
                    f_out    <= f_new;
                    iter_cnt <= iter_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_block_compare_engine.sv
// Directed self-checking bench for z80_block_compare_engine with a req/ack memory model.
// Expected F values switch with Z80_UNDOC_FLAGS_EN where the undocumented bits differ.
module tb_z80_block_compare_engine;

    logic        clk = 1'b0;
    logic        reset_n, start, mode_dec, mode_rep, abort;
    logic [7:0]  a_in, f_in, mem_rdata, f_out;
    logic [15:0] hl_in, bc_in, mem_addr, hl_out, bc_out, iter_cnt;
    logic        mem_req, mem_ack, busy, done;

    logic [7:0]  mem [0:65535];
    int          wait_n = 0;
    int          req_cnt = 0;
    logic        block_en = 1'b0;
    logic [15:0] block_addr = '0;

    int checks = 0;
    int fails  = 0;
    int cyc;

`ifdef Z80_UNDOC_FLAGS_EN
    localparam logic [7:0] F_CPDR  = 8'h9B;
    localparam logic [7:0] F_WRAP  = 8'h9E;
    localparam logic [7:0] F_ABORT = 8'hBE;
`else
    localparam logic [7:0] F_CPDR  = 8'hBB;
    localparam logic [7:0] F_WRAP  = 8'h96;
    localparam logic [7:0] F_ABORT = 8'h96;
`endif

    always #5 clk = ~clk;

    z80_block_compare_engine dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode_dec(mode_dec),
        .mode_rep(mode_rep), .abort(abort), .a_in(a_in), .hl_in(hl_in),
        .bc_in(bc_in), .f_in(f_in), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .hl_out(hl_out), .bc_out(bc_out), .f_out(f_out), .iter_cnt(iter_cnt)
    );

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && (req_cnt >= wait_n) && !(block_en && mem_addr == block_addr);

    always @(posedge clk) begin
        if (mem_req && !mem_ack) req_cnt <= req_cnt + 1;
        else                     req_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic dec, input logic rep, input logic [7:0] a,
                          input logic [15:0] hl, input logic [15:0] bc, input logic [7:0] f);
        mode_dec = dec; mode_rep = rep; a_in = a; hl_in = hl; bc_in = bc; f_in = f;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
    endtask

    // cyc counts the start cycle as 1; returns the cycle number in which done is high
    task automatic wait_done(input string tag);
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        cyc++;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; mode_dec = 1'b0; mode_rep = 1'b0; abort = 1'b0;
        a_in = '0; hl_in = '0; bc_in = '0; f_in = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1000] = 8'h41;
        mem[16'h2002] = 8'h01; mem[16'h2001] = 8'h02; mem[16'h2000] = 8'h03;
        mem[16'h3000] = 8'h10; mem[16'h3001] = 8'h7F;
        mem[16'hFFFF] = 8'h34;
        mem[16'h5005] = 8'h01;
        #22;
        check("rst_busy", busy, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hl", hl_out, 16'h0000);
        check("rst_f", f_out, 8'h00);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // CPI match, zero wait
        launch(1'b0, 1'b0, 8'h41, 16'h1000, 16'h0003, 8'h00);
        check("cpi_busy", busy, 1'b1);
        wait_done("cpi");
        check("cpi_cycles", cyc, 4);
        check("cpi_hl", hl_out, 16'h1001);
        check("cpi_bc", bc_out, 16'h0002);
        check("cpi_f", f_out, 8'h46);
        check("cpi_iter", iter_cnt, 16'h0001);
        check("cpi_busy_end", busy, 1'b0);
        @(posedge clk); #1;
        check("cpi_done_pulse", done, 1'b0);

        // CPDR, no match, BC exhausts; F5/F3/C come from f_in
        launch(1'b1, 1'b1, 8'h00, 16'h2002, 16'h0003, 8'h29);
        wait_done("cpdr");
        check("cpdr_hl", hl_out, 16'h1FFF);
        check("cpdr_bc", bc_out, 16'h0000);
        check("cpdr_f", f_out, F_CPDR);
        check("cpdr_iter", iter_cnt, 16'h0003);
        @(posedge clk); #1;

        // CPIR, match on second byte
        launch(1'b0, 1'b1, 8'h7F, 16'h3000, 16'h0005, 8'h00);
        wait_done("cpir");
        check("cpir_hl", hl_out, 16'h3002);
        check("cpir_bc", bc_out, 16'h0003);
        check("cpir_f", f_out, 8'h46);
        check("cpir_iter", iter_cnt, 16'h0002);
        @(posedge clk); #1;

        // CPI at HL=FFFF with BC=0: both wrap, V=1
        launch(1'b0, 1'b0, 8'h12, 16'hFFFF, 16'h0000, 8'h00);
        wait_done("wrap");
        check("wrap_hl", hl_out, 16'h0000);
        check("wrap_bc", bc_out, 16'hFFFF);
        check("wrap_f", f_out, F_WRAP);
        @(posedge clk); #1;

        // three wait states; a start during the op must be ignored
        wait_n = 3;
        launch(1'b0, 1'b0, 8'h00, 16'h4000, 16'h0001, 8'h00);
        check("ws_busy", busy, 1'b1);
        check("ws_req0", mem_req, 1'b1);
        check("ws_addr0", mem_addr, 16'h4000);
        start = 1'b1; hl_in = 16'hABCD;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
        check("ws_req1", mem_req, 1'b1);
        check("ws_addr1", mem_addr, 16'h4000);
        check("ws_noupd_bc", bc_out, 16'h0001);
        @(posedge clk); #1;
        cyc++;
        check("ws_req2", mem_req, 1'b1);
        check("ws_addr2", mem_addr, 16'h4000);
        check("ws_noupd_iter", iter_cnt, 16'h0000);
        wait_done("ws");
        check("ws_cycles", cyc, 7);
        check("ws_hl", hl_out, 16'h4001);
        check("ws_bc", bc_out, 16'h0000);
        check("ws_f", f_out, 8'h42);
        wait_n = 0;
        @(posedge clk); #1;
        check("ws_idle", busy, 1'b0);

        // CPDR aborted while the second read is stalled
        block_en = 1'b1; block_addr = 16'h5004;
        launch(1'b1, 1'b1, 8'h00, 16'h5005, 16'h0004, 8'h00);
        while (!(mem_req && mem_addr == 16'h5004) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ab_stall", mem_req, 1'b1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("ab_done", done, 1'b1);
        check("ab_req", mem_req, 1'b0);
        check("ab_hl", hl_out, 16'h5004);
        check("ab_bc", bc_out, 16'h0003);
        check("ab_f", f_out, F_ABORT);
        check("ab_iter", iter_cnt, 16'h0001);
        block_en = 1'b0;
        @(posedge clk); #1;

        // asynchronous reset while in EXEC, then a fresh operation
        launch(1'b0, 1'b0, 8'h41, 16'h1000, 16'h0003, 8'h00);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("rx_busy", busy, 1'b0);
        check("rx_hl", hl_out, 16'h0000);
        check("rx_bc", bc_out, 16'h0000);
        check("rx_iter", iter_cnt, 16'h0000);
        @(posedge clk); #1;
        check("rx_nodone", done, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        launch(1'b0, 1'b0, 8'h41, 16'h1000, 16'h0003, 8'h00);
        wait_done("rx2");
        check("rx2_hl", hl_out, 16'h1001);
        check("rx2_f", f_out, 8'h46);
        check("rx2_iter", iter_cnt, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
